// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer.
// Decodes on the input side; buffers hold the extended immediate, tag and illegal flag.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
    logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic            accept, drain;

    always_comb begin
        imm32   = '0;
        dec_ill = 1'b0;
        case (imm_src)
            3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
            3'b011: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            3'b100: imm32 = {instr[31:12], 12'b0};
            3'b101: imm32 = {27'b0, instr[19:15]};
            3'b110: dec_ill = 1'b1;
            default: ;
        endcase
    end

    // Every 32-bit form already carries its sign in bit 31 (zero for Z), so a plain
    // sign-extension widens all formats correctly.
    assign dec_imm = XLEN'($signed(imm32));

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        out_ill_d  = out_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        err_d      = err_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        out_imm_d = dec_imm;
                        out_tag_d = in_tag;
                        out_ill_d = dec_ill;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        out_imm_d = dec_imm;
                        out_tag_d = in_tag;
                        out_ill_d = dec_ill;
                    end else if (accept) begin
                        state_d    = StTwo;
                        skid_imm_d = dec_imm;
                        skid_tag_d = in_tag;
                        skid_ill_d = dec_ill;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a drain can occur
                    if (drain) begin
                        state_d   = StOne;
                        out_imm_d = skid_imm_q;
                        out_tag_d = skid_tag_q;
                        out_ill_d = skid_ill_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
            if (accept && dec_ill && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            out_ill_q  <= out_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
            err_q      <= err_d;
        end
    end

    assign imm_ext     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_ill_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a default XLEN=32 instance and an XLEN=64/ERR_W=2
// instance share the same stimulus.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;

    logic        in_ready_a, out_valid_a, ill_a;
    logic [31:0] imm_a;
    logic [4:0]  tag_a;
    logic [7:0]  err_a;

    logic        in_ready_b, out_valid_b, ill_b;
    logic [63:0] imm_b;
    logic [4:0]  tag_b;
    logic [1:0]  err_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(5), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid_a),
        .out_ready(out_ready), .imm_ext(imm_a), .out_tag(tag_a), .out_illegal(ill_a),
        .err_count(err_a)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid_b),
        .out_ready(out_ready), .imm_ext(imm_b), .out_tag(tag_b), .out_illegal(ill_b),
        .err_count(err_b)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One entry through an idle stage with out_ready high; checks the cycle after accept.
    task automatic dec(input string name, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] e32, input logic [63:0] e64, input logic ill);
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = src;
        in_tag   = 5'd30;
        tick();
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid_a), 64'd1);
        chk({name, "_imm32"}, 64'(imm_a), 64'(e32));
        chk({name, "_imm64"}, imm_b, e64);
        chk({name, "_ill"}, 64'(ill_a), 64'(ill));
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'hFFF00093;
        imm_src   = 3'b110;
        in_tag    = 5'd9;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid_a), 64'd0);
        chk("rst_imm", 64'(imm_a), 64'd0);
        chk("rst_tag", 64'(tag_a), 64'd0);
        chk("rst_ill", 64'(ill_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_no_accept", 64'(out_valid_a), 64'd0);

        dec("dec_i", 32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        dec("dec_s", 32'hFE20AE23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        dec("dec_b", 32'hFE000FE3, 3'b010, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0);
        dec("dec_j", 32'h0080006F, 3'b011, 32'h00000008, 64'h0000000000000008, 1'b0);
        dec("dec_z", 32'h800F8073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0);
        dec("dec_u", 32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0);
        dec("dec_u_neg", 32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        dec("dec_none", 32'hFFFFFFFF, 3'b111, 32'h0, 64'h0, 1'b0);
        chk("idle_empty", 64'(out_valid_a), 64'd0);

        // Back-pressure: tags 1..4, out_ready low for three edges
        out_ready = 1'b0;
        imm_src   = 3'b000;
        in_valid  = 1'b1;
        instr     = 32'd1 << 20;
        in_tag    = 5'd1;
        tick();
        chk("bp_first", 64'(tag_a), 64'd1);
        chk("bp_ready1", 64'(in_ready_a), 64'd1);
        instr  = 32'd2 << 20;
        in_tag = 5'd2;
        tick();
        chk("bp_ready_low", 64'(in_ready_a), 64'd0);
        chk("bp_hold_tag", 64'(tag_a), 64'd1);
        instr  = 32'd3 << 20;
        in_tag = 5'd3;
        tick();
        chk("bp_hold_tag2", 64'(tag_a), 64'd1);
        chk("bp_hold_imm", 64'(imm_a), 64'd1);
        chk("bp_still_full", 64'(in_ready_b), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out2", 64'(tag_a), 64'd2);
        chk("bp_out2_imm", imm_b, 64'd2);
        chk("bp_ready_back", 64'(in_ready_a), 64'd1);
        tick();
        chk("bp_out3", 64'(tag_a), 64'd3);
        chk("bp_out3_valid", 64'(out_valid_a), 64'd1);
        instr  = 32'd4 << 20;
        in_tag = 5'd4;
        tick();
        chk("bp_out4", 64'(tag_a), 64'd4);
        chk("bp_out4_imm", 64'(imm_a), 64'd4);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(out_valid_a), 64'd0);

        // Illegal format: five back-to-back accepts
        in_valid = 1'b1;
        imm_src  = 3'b110;
        instr    = 32'hFFFFFFFF;
        for (int k = 1; k <= 5; k++) begin
            in_tag = 5'(k + 16);
            tick();
            chk("ill_flag", 64'(ill_b), 64'd1);
            chk("ill_imm", imm_b, 64'd0);
            chk("ill_tag", 64'(tag_b), 64'(k + 16));
            chk("ill_err_sat", 64'(err_b), (k < 3) ? 64'(k) : 64'd3);
            chk("ill_err8", 64'(err_a), 64'(k));
        end
        in_valid = 1'b0;
        tick();

        // Flush in TWO with a simultaneous in_valid and out_ready
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 3'b000;
        in_tag    = 5'd5;
        tick();
        in_tag = 5'd6;
        tick();
        chk("fl_two", 64'(in_ready_a), 64'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_tag    = 5'd7;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid_a), 64'd0);
        chk("fl_ready", 64'(in_ready_a), 64'd1);
        tick();
        chk("fl_no_resurrect", 64'(out_valid_a), 64'd0);

        // Flush in ONE while accepting an illegal entry: no count
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd8;
        tick();
        flush   = 1'b1;
        imm_src = 3'b110;
        in_tag  = 5'd9;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", 64'(out_valid_a), 64'd0);
        chk("fl1_err", 64'(err_a), 64'd5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm_src   = 3'b000;
        instr     = 32'd10 << 20;
        in_tag    = 5'd10;
        tick();
        in_valid = 1'b0;
        chk("fl1_next_tag", 64'(tag_a), 64'd10);
        chk("fl1_next_imm", 64'(imm_a), 64'd10);
        tick();

        // Reset mid-stream in TWO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 3'b110;
        in_tag    = 5'd11;
        tick();
        imm_src = 3'b000;
        in_tag  = 5'd12;
        tick();
        chk("rs_pre_ill", 64'(ill_a), 64'd1);
        chk("rs_pre_err", 64'(err_a), 64'd6);
        reset = 1'b1;
        tick();
        chk("rs_valid", 64'(out_valid_a), 64'd0);
        chk("rs_imm", imm_b, 64'd0);
        chk("rs_tag", 64'(tag_a), 64'd0);
        chk("rs_ill", 64'(ill_a), 64'd0);
        chk("rs_err", 64'(err_a), 64'd0);
        chk("rs_err_b", 64'(err_b), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rs_ready", 64'(in_ready_a), 64'd1);
        chk("rs_empty", 64'(out_valid_b), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
